// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: load types, lane masks, FSM states.
package dmem_responder_pkg;

  localparam logic [2:0] LT_LB   = 3'b000;
  localparam logic [2:0] LT_LH   = 3'b001;
  localparam logic [2:0] LT_LW   = 3'b010;
  localparam logic [2:0] LT_LBU  = 3'b100;
  localparam logic [2:0] LT_LHU  = 3'b101;
  localparam logic [2:0] LT_NONE = 3'b111;

  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_B    = 4'b0001;
  localparam logic [3:0] MASK_H    = 4'b0011;
  localparam logic [3:0] MASK_W    = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_load_align.sv
// Load extraction from a RAM word: byte/half/word select, sign/zero extension and
// alignment-fault detection. Purely combinational.
module dmem_load_align
  import dmem_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  load_type,
  output logic [31:0] result,
  output logic        fault
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];

    result = '0;
    fault  = 1'b0;
    case (load_type)
      LT_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  result = {24'd0, byte_sel};
      LT_LH:   begin
        fault  = offset[0];
        result = {{16{half_sel[15]}}, half_sel};
      end
      LT_LHU:  begin
        fault  = offset[0];
        result = {16'd0, half_sel};
      end
      LT_LW:   begin
        fault  = |offset;
        result = word;
      end
      default: fault = 1'b1;  // LT_NONE and unused encodings
    endcase
    if (fault) result = '0;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte-lane stores, extended loads and WAIT_STATES
// stall cycles. Define DMEM_BOUNDS_CHECK_EN to fault on address bits above the RAM.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_enable,
  input  logic        wr_enable,
  input  logic [31:0] read_addr,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  write_byte_enable,
  input  logic [2:0]  load_type,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        misaligned_fault
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        cap_wr, cap_rd;
  logic [31:0] cap_addr, cap_data;
  logic [3:0]  cap_mask;
  logic [2:0]  cap_lt;

  logic [31:0] mem [DEPTH];

  logic        req, go_resp, store_ok, oob;
  logic        cur_wr, cur_rd;
  logic [31:0] cur_addr, cur_data;
  logic [3:0]  cur_mask, wmask;
  logic [2:0]  cur_lt;
  logic [1:0]  offset;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0] wdata, load_result;
  logic        align_fault, load_fault;

  assign req = read_enable | wr_enable;

  // With no wait states the access completes on the accepting edge, so the live inputs
  // feed the datapath in IDLE; otherwise the captured request does.
  always_comb begin
    if (state == IDLE) begin
      cur_wr   = wr_enable;
      cur_rd   = read_enable & ~wr_enable;
      cur_addr = wr_enable ? wr_addr : read_addr;
      cur_data = wr_data;
      cur_mask = write_byte_enable;
      cur_lt   = load_type;
    end else begin
      cur_wr   = cap_wr;
      cur_rd   = cap_rd;
      cur_addr = cap_addr;
      cur_data = cap_data;
      cur_mask = cap_mask;
      cur_lt   = cap_lt;
    end
  end

  assign go_resp  = ((state == IDLE) && req && (WAIT_STATES == 0)) ||
                    ((state == WAIT) && (wait_cnt == 4'd0));
  assign stall    = ((state == IDLE) && req) || (state == WAIT);
  assign offset   = cur_addr[1:0];
  assign word_idx = cur_addr[ADDR_WIDTH+1:2];
  assign wmask    = 4'(cur_mask << offset);
  assign wdata    = cur_data << {offset, 3'b000};

`ifdef DMEM_BOUNDS_CHECK_EN
  assign oob = |cur_addr[31:ADDR_WIDTH+2];
`else
  logic addr_hi_unused;
  assign addr_hi_unused = ^cur_addr[31:ADDR_WIDTH+2];
  assign oob = 1'b0;
`endif

  assign store_ok   = cur_wr && (cur_mask != MASK_NONE) && !oob;
  assign load_fault = align_fault | oob;

  dmem_load_align u_align (
    .word      (mem[word_idx]),
    .offset    (offset),
    .load_type (cur_lt),
    .result    (load_result),
    .fault     (align_fault)
  );

  // RAM is not reset; the rst term keeps an aborted access from writing.
  always_ff @(posedge clk) begin
    if (rst && go_resp && store_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      wait_cnt         <= 4'd0;
      cap_wr           <= 1'b0;
      cap_rd           <= 1'b0;
      cap_addr         <= '0;
      cap_data         <= '0;
      cap_mask         <= '0;
      cap_lt           <= LT_NONE;
      rdata            <= '0;
      rdata_valid      <= 1'b0;
      misaligned_fault <= 1'b0;
    end else begin
      rdata            <= '0;
      rdata_valid      <= 1'b0;
      misaligned_fault <= 1'b0;
      case (state)
        IDLE: if (req) begin
          cap_wr   <= cur_wr;
          cap_rd   <= cur_rd;
          cap_addr <= cur_addr;
          cap_data <= cur_data;
          cap_mask <= cur_mask;
          cap_lt   <= cur_lt;
          wait_cnt <= WAIT_LOAD;
          state    <= (WAIT_STATES > 0) ? WAIT : RESP;
        end
        WAIT: begin
          if (wait_cnt == 4'd0) state <= RESP;
          else wait_cnt <= wait_cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
      if (go_resp) begin
        if (cur_wr) begin
          misaligned_fault <= !store_ok;
        end else if (cur_rd) begin
          rdata            <= load_fault ? 32'd0 : load_result;
          rdata_valid      <= 1'b1;
          misaligned_fault <= load_fault;
        end
      end
    end
  end

endmodule
